// File: rtl/hdlc_tx_pkg.sv
// Shared HDLC transmit definitions: byte kinds, frame sequencer states and line patterns.
package hdlc_tx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned FCS_W  = 16;
  localparam int unsigned KIND_W = 2;

  localparam logic [BYTE_W-1:0] FLAG_BYTE  = 8'h7E;
  localparam logic [BYTE_W-1:0] ABORT_BYTE = 8'hFE;
  localparam logic [BYTE_W-1:0] IDLE_BYTE  = 8'hFF;

  typedef enum logic [KIND_W-1:0] {
    KIND_IDLE  = 2'd0,
    KIND_FLAG  = 2'd1,
    KIND_DATA  = 2'd2,
    KIND_ABORT = 2'd3
  } tx_kind_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    FCS_LO = 3'd3,
    FCS_HI = 3'd4,
    END    = 3'd5,
    ABORT  = 3'd6
  } tx_state_t;

  // A frame must carry at least one data byte and fit the buffer.
  function automatic logic sizeInRange(input logic [BYTE_W-1:0] size, input int unsigned maxBytes);
    return (size != 8'd0) && (32'(size) <= maxBytes);
  endfunction

endpackage

// File: rtl/hdlc_tx_bytecnt.sv
// Data byte counter: holds the frame size and flags the slot that takes the last data byte.
module hdlc_tx_bytecnt
  import hdlc_tx_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] size,
  input  logic              inc,
  output logic              lastByte_c
);

  logic [BYTE_W-1:0] sizeQ;
  logic [BYTE_W-1:0] countQ;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sizeQ  <= '0;
      countQ <= '0;
    end else if (load) begin
      sizeQ  <= size;
      countQ <= '0;
    end else if (inc) begin
      countQ <= countQ + 8'd1;
    end
  end

  // True while the byte about to be taken brings the count up to the frame size.
  assign lastByte_c = ((countQ + 8'd1) == sizeQ);

endmodule

// File: rtl/hdlc_tx_frame_ctrl.sv
// HDLC transmit byte sequencer: picks idle/flag/data/FCS/abort for each serializer slot
// and generates the Tx status bits.
module hdlc_tx_frame_ctrl
  import hdlc_tx_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 126
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tx_Enable,
  input  logic              Tx_AbortFrame,
  input  logic [BYTE_W-1:0] Tx_FrameSize,
  input  logic [BYTE_W-1:0] Tx_DataOutBuff,
  input  logic              Tx_NewByte,
  input  logic              Tx_FCSDone,
  input  logic [FCS_W-1:0]  Tx_FCS,
  output logic              Tx_RdBuff,
  output logic              Tx_StartFCS,
  output logic              Tx_WriteFCS,
  output logic [BYTE_W-1:0] Tx_Data,
  output logic [KIND_W-1:0] Tx_ByteKind,
  output logic              Tx_ValidFrame,
  output logic              Tx_Done,
  output logic              Tx_AbortedTrans
);

  tx_state_t stateQ, stateD;
  logic      abortPendQ, abortPendD;

  logic accept_c, inFrame_c, abortReq_c, fcsErr_c, abortSlot_c, lastByte_c, cntInc_c;

  logic [BYTE_W-1:0] dataD;
  tx_kind_t          kindD;
  logic              rdD, startD, writeD, validD, doneD, abortedD;

  assign accept_c    = (stateQ == IDLE) && Tx_Enable && sizeInRange(Tx_FrameSize, MAX_FRAME_BYTES);
  assign inFrame_c   = stateQ inside {START, DATA, FCS_LO, FCS_HI, END};
  assign abortReq_c  = Tx_AbortFrame && (accept_c || (stateQ == START) || (Tx_ValidFrame && inFrame_c));
  assign fcsErr_c    = (stateQ == FCS_LO) && !Tx_FCSDone;
  assign abortSlot_c = Tx_NewByte && inFrame_c && (abortPendQ || fcsErr_c);

  hdlc_tx_bytecnt u_bytecnt (
    .Clk        (Clk),
    .Rst        (Rst),
    .load       (accept_c),
    .size       (Tx_FrameSize),
    .inc        (cntInc_c),
    .lastByte_c (lastByte_c)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stateQ          <= IDLE;
      abortPendQ      <= 1'b0;
      Tx_Data         <= IDLE_BYTE;
      Tx_ByteKind     <= KIND_IDLE;
      Tx_RdBuff       <= 1'b0;
      Tx_StartFCS     <= 1'b0;
      Tx_WriteFCS     <= 1'b0;
      Tx_ValidFrame   <= 1'b0;
      Tx_Done         <= 1'b1;
      Tx_AbortedTrans <= 1'b0;
    end else begin
      stateQ          <= stateD;
      abortPendQ      <= abortPendD;
      Tx_Data         <= dataD;
      Tx_ByteKind     <= kindD;
      Tx_RdBuff       <= rdD;
      Tx_StartFCS     <= startD;
      Tx_WriteFCS     <= writeD;
      Tx_ValidFrame   <= validD;
      Tx_Done         <= doneD;
      Tx_AbortedTrans <= abortedD;
    end
  end

  always_comb begin
    stateD = stateQ;
    if (abortSlot_c) begin
      stateD = ABORT;
    end else begin
      case (stateQ)
        IDLE:    if (accept_c) stateD = START;
        START:   if (Tx_NewByte) stateD = DATA;
        DATA:    if (Tx_NewByte && lastByte_c) stateD = FCS_LO;
        FCS_LO:  if (Tx_NewByte) stateD = FCS_HI;
        FCS_HI:  if (Tx_NewByte) stateD = END;
        END:     if (Tx_NewByte) stateD = IDLE;
        ABORT:   stateD = IDLE;
        default: stateD = IDLE;
      endcase
    end
    // A pending abort only survives while a frame is still being sent.
    abortPendD = 1'b0;
    if ((stateD != IDLE) && (stateD != ABORT)) abortPendD = abortPendQ || abortReq_c;
  end

  always_comb begin
    dataD    = Tx_Data;
    kindD    = tx_kind_t'(Tx_ByteKind);
    rdD      = 1'b0;
    startD   = 1'b0;
    writeD   = 1'b0;
    cntInc_c = 1'b0;
    validD   = Tx_ValidFrame;
    doneD    = Tx_Done;
    abortedD = Tx_AbortedTrans;
    if (abortSlot_c) begin
      dataD    = ABORT_BYTE;
      kindD    = KIND_ABORT;
      validD   = 1'b0;
      abortedD = 1'b1;
    end else begin
      case (stateQ)
        IDLE: begin
          // Entering IDLE after the closing flag retires the frame one cycle later.
          validD = 1'b0;
          if (accept_c) begin
            doneD    = 1'b0;
            abortedD = 1'b0;
          end else begin
            doneD = 1'b1;
          end
          if (Tx_NewByte) begin
            dataD = IDLE_BYTE;
            kindD = KIND_IDLE;
          end
        end
        START: if (Tx_NewByte) begin
          dataD  = FLAG_BYTE;
          kindD  = KIND_FLAG;
          startD = 1'b1;
          validD = 1'b1;
        end
        DATA: if (Tx_NewByte) begin
          dataD    = Tx_DataOutBuff;
          kindD    = KIND_DATA;
          rdD      = 1'b1;
          cntInc_c = 1'b1;
          writeD   = lastByte_c;
        end
        FCS_LO: if (Tx_NewByte) begin
          dataD = Tx_FCS[7:0];
          kindD = KIND_DATA;
        end
        FCS_HI: if (Tx_NewByte) begin
          dataD = Tx_FCS[15:8];
          kindD = KIND_DATA;
        end
        END: if (Tx_NewByte) begin
          dataD = FLAG_BYTE;
          kindD = KIND_FLAG;
        end
        ABORT:   doneD = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// Directed bench for hdlc_tx_frame_ctrl: per-cycle vectors with hand-computed slot outputs.
module tb_hdlc_tx_frame_ctrl;
  import hdlc_tx_pkg::*;

  typedef struct packed {
    logic [3:0]  ctl;       // {newByte, enable, abort, fcsDone}
    logic [7:0]  size;
    logic [7:0]  bufByte;
    logic [15:0] fcs;
    logic [7:0]  expData;
    logic [1:0]  expKind;
    logic [5:0]  expFlags;  // {rdBuff, startFcs, writeFcs, validFrame, done, abortedTrans}
  } vec_t;

  logic        Clk, Rst;
  logic        Tx_Enable, Tx_AbortFrame, Tx_NewByte, Tx_FCSDone;
  logic [7:0]  Tx_FrameSize, Tx_DataOutBuff;
  logic [15:0] Tx_FCS;
  logic        Tx_RdBuff, Tx_StartFCS, Tx_WriteFCS, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans;
  logic [7:0]  Tx_Data;
  logic [1:0]  Tx_ByteKind;

  int   tests  = 0;
  int   failed = 0;
  vec_t vecs[$];

  localparam logic [15:0] F1 = 16'h5AC3;
  localparam logic [15:0] F2 = 16'hBEEF;

  hdlc_tx_frame_ctrl dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Tx_Enable       (Tx_Enable),
    .Tx_AbortFrame   (Tx_AbortFrame),
    .Tx_FrameSize    (Tx_FrameSize),
    .Tx_DataOutBuff  (Tx_DataOutBuff),
    .Tx_NewByte      (Tx_NewByte),
    .Tx_FCSDone      (Tx_FCSDone),
    .Tx_FCS          (Tx_FCS),
    .Tx_RdBuff       (Tx_RdBuff),
    .Tx_StartFCS     (Tx_StartFCS),
    .Tx_WriteFCS     (Tx_WriteFCS),
    .Tx_Data         (Tx_Data),
    .Tx_ByteKind     (Tx_ByteKind),
    .Tx_ValidFrame   (Tx_ValidFrame),
    .Tx_Done         (Tx_Done),
    .Tx_AbortedTrans (Tx_AbortedTrans)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [3:0] ctl, input logic [7:0] size, input logic [7:0] bufByte,
                              input logic [15:0] fcs, input logic [7:0] ed, input logic [1:0] ek,
                              input logic [5:0] ef);
    vec_t v;
    v.ctl = ctl; v.size = size; v.bufByte = bufByte; v.fcs = fcs;
    v.expData = ed; v.expKind = ek; v.expFlags = ef;
    return v;
  endfunction

  task automatic checkOut(input int id, input logic [7:0] ed, input logic [1:0] ek, input logic [5:0] ef);
    logic [5:0] act;
    act = {Tx_RdBuff, Tx_StartFCS, Tx_WriteFCS, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans};
    tests++;
    if (Tx_Data !== ed) begin
      failed++;
      $display("FAIL vec%0d data: got %h want %h", id, Tx_Data, ed);
    end
    tests++;
    if (Tx_ByteKind !== ek) begin
      failed++;
      $display("FAIL vec%0d kind: got %0d want %0d", id, Tx_ByteKind, ek);
    end
    tests++;
    if (act !== ef) begin
      failed++;
      $display("FAIL vec%0d flags(rd,start,wr,valid,done,abrt): got %b want %b", id, act, ef);
    end
  endtask

  // One vector = inputs for one cycle, check just after the edge, then 7 quiet cycles.
  task automatic applyVec(input vec_t v, input int id);
    {Tx_NewByte, Tx_Enable, Tx_AbortFrame, Tx_FCSDone} = v.ctl;
    Tx_FrameSize   = v.size;
    Tx_DataOutBuff = v.bufByte;
    Tx_FCS         = v.fcs;
    @(posedge Clk);
    #1;
    checkOut(id, v.expData, v.expKind, v.expFlags);
    Tx_NewByte    = 1'b0;
    Tx_Enable     = 1'b0;
    Tx_AbortFrame = 1'b0;
    repeat (7) @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1;
    Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_NewByte = 1'b0; Tx_FCSDone = 1'b1;
    Tx_FrameSize = 8'd0; Tx_DataOutBuff = 8'd0; Tx_FCS = F1;

    // idle slots
    repeat (3) vecs.push_back(mk(4'b1001, 8'd0, 8'h00, F1, 8'hFF, KIND_IDLE, 6'b000010));
    // normal 3-byte frame, with an enable ignored mid-frame
    vecs.push_back(mk(4'b0101, 8'd3, 8'h00, F1, 8'hFF, KIND_IDLE, 6'b000000));
    vecs.push_back(mk(4'b1001, 8'd3, 8'h00, F1, 8'h7E, KIND_FLAG, 6'b010100));
    vecs.push_back(mk(4'b1001, 8'd3, 8'hA1, F1, 8'hA1, KIND_DATA, 6'b100100));
    vecs.push_back(mk(4'b0101, 8'd9, 8'h00, F1, 8'hA1, KIND_DATA, 6'b000100));
    vecs.push_back(mk(4'b1001, 8'd3, 8'hB2, F1, 8'hB2, KIND_DATA, 6'b100100));
    vecs.push_back(mk(4'b1001, 8'd3, 8'hC3, F1, 8'hC3, KIND_DATA, 6'b101100));
    vecs.push_back(mk(4'b1001, 8'd3, 8'h00, F1, 8'hC3, KIND_DATA, 6'b000100));
    vecs.push_back(mk(4'b1001, 8'd3, 8'h00, F1, 8'h5A, KIND_DATA, 6'b000100));
    vecs.push_back(mk(4'b1001, 8'd3, 8'h00, F1, 8'h7E, KIND_FLAG, 6'b000100));
    vecs.push_back(mk(4'b0001, 8'd3, 8'h00, F1, 8'h7E, KIND_FLAG, 6'b000010));
    vecs.push_back(mk(4'b1001, 8'd3, 8'h00, F1, 8'hFF, KIND_IDLE, 6'b000010));
    // abort after second data byte of a 5-byte frame
    vecs.push_back(mk(4'b0101, 8'd5, 8'h00, F1, 8'hFF, KIND_IDLE, 6'b000000));
    vecs.push_back(mk(4'b1001, 8'd5, 8'h00, F1, 8'h7E, KIND_FLAG, 6'b010100));
    vecs.push_back(mk(4'b1001, 8'd5, 8'h11, F1, 8'h11, KIND_DATA, 6'b100100));
    vecs.push_back(mk(4'b1001, 8'd5, 8'h22, F1, 8'h22, KIND_DATA, 6'b100100));
    vecs.push_back(mk(4'b0011, 8'd5, 8'h00, F1, 8'h22, KIND_DATA, 6'b000100));
    vecs.push_back(mk(4'b1001, 8'd5, 8'h33, F1, 8'hFE, KIND_ABORT, 6'b000001));
    vecs.push_back(mk(4'b0001, 8'd5, 8'h00, F1, 8'hFE, KIND_ABORT, 6'b000011));
    vecs.push_back(mk(4'b1001, 8'd5, 8'h00, F1, 8'hFF, KIND_IDLE, 6'b000011));
    // size 0 and 127 rejected; 126 accepted together with an abort in the same cycle
    vecs.push_back(mk(4'b0101, 8'd0,   8'h00, F1, 8'hFF, KIND_IDLE, 6'b000011));
    vecs.push_back(mk(4'b0101, 8'd127, 8'h00, F1, 8'hFF, KIND_IDLE, 6'b000011));
    vecs.push_back(mk(4'b1001, 8'd127, 8'h00, F1, 8'hFF, KIND_IDLE, 6'b000011));
    vecs.push_back(mk(4'b0111, 8'd126, 8'h00, F1, 8'hFF, KIND_IDLE, 6'b000000));
    vecs.push_back(mk(4'b1001, 8'd126, 8'h00, F1, 8'hFE, KIND_ABORT, 6'b000001));
    vecs.push_back(mk(4'b0001, 8'd126, 8'h00, F1, 8'hFE, KIND_ABORT, 6'b000011));
    // FCS not ready at the FCS slot
    vecs.push_back(mk(4'b0100, 8'd1, 8'h00, F1, 8'hFE, KIND_ABORT, 6'b000000));
    vecs.push_back(mk(4'b1000, 8'd1, 8'h00, F1, 8'h7E, KIND_FLAG, 6'b010100));
    vecs.push_back(mk(4'b1000, 8'd1, 8'h9C, F1, 8'h9C, KIND_DATA, 6'b101100));
    vecs.push_back(mk(4'b1000, 8'd1, 8'h00, F1, 8'hFE, KIND_ABORT, 6'b000001));
    vecs.push_back(mk(4'b0000, 8'd1, 8'h00, F1, 8'hFE, KIND_ABORT, 6'b000011));

    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    checkOut(0, 8'hFF, KIND_IDLE, 6'b000010);

    for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i + 1);

    // reset in the middle of a frame, then a 2-byte frame with enable on a slot cycle
    applyVec(mk(4'b0101, 8'd5, 8'h00, F2, 8'hFE, KIND_ABORT, 6'b000000), 100);
    applyVec(mk(4'b1001, 8'd5, 8'h00, F2, 8'h7E, KIND_FLAG, 6'b010100), 101);
    applyVec(mk(4'b1001, 8'd5, 8'hD0, F2, 8'hD0, KIND_DATA, 6'b100100), 102);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    checkOut(103, 8'hFF, KIND_IDLE, 6'b000010);
    applyVec(mk(4'b1101, 8'd2, 8'h00, F2, 8'hFF, KIND_IDLE, 6'b000000), 104);
    applyVec(mk(4'b1001, 8'd2, 8'h00, F2, 8'h7E, KIND_FLAG, 6'b010100), 105);
    applyVec(mk(4'b1001, 8'd2, 8'hD1, F2, 8'hD1, KIND_DATA, 6'b100100), 106);
    applyVec(mk(4'b1001, 8'd2, 8'hD2, F2, 8'hD2, KIND_DATA, 6'b101100), 107);
    applyVec(mk(4'b1001, 8'd2, 8'h00, F2, 8'hEF, KIND_DATA, 6'b000100), 108);
    applyVec(mk(4'b1001, 8'd2, 8'h00, F2, 8'hBE, KIND_DATA, 6'b000100), 109);
    applyVec(mk(4'b1001, 8'd2, 8'h00, F2, 8'h7E, KIND_FLAG, 6'b000100), 110);
    applyVec(mk(4'b0001, 8'd2, 8'h00, F2, 8'h7E, KIND_FLAG, 6'b000010), 111);
    applyVec(mk(4'b1001, 8'd2, 8'h00, F2, 8'hFF, KIND_IDLE, 6'b000010), 112);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
